fdiv_issue_stage: RTL and testbench

- Sequential front/back-end wrapper around the combinational-latency Newton-Raphson FP32 divide core.
- Accepts operands on a valid/ready handshake and resolves IEEE special cases locally.
- For finite normal operands, issues exponent-normalised operands to the core, counts the core latency, then rebuilds the final exponent and sign.
- Reports a rounded-to-core-precision result plus status flags on a valid/ready output.

---
 rtl/fdiv_issue_stage_if.sv | 39 +++
 rtl/fdiv_issue_stage.sv | 172 +++++++++++++++++
 tb/tb_fdiv_issue_stage.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fdiv_issue_stage_if.sv
// Handshake and divide-core bus for fdiv_issue_stage. The sticky-flag signals
// exist only when FDIV_STICKY_FLAGS_EN is defined.
interface fdiv_issue_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic [XLEN-1:0] div_a;
    logic [XLEN-1:0] div_b;
    logic [XLEN-1:0] div_result;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [3:0]      out_flags;
`ifdef FDIV_STICKY_FLAGS_EN
    logic            flags_clr;
    logic [3:0]      sticky_flags;

    modport slave (
        input  in_valid, in_a, in_b, div_result, out_ready, flags_clr,
        output in_ready, div_a, div_b, out_valid, out_result, out_flags, sticky_flags
    );
    modport master (
        output in_valid, in_a, in_b, div_result, out_ready, flags_clr,
        input  in_ready, div_a, div_b, out_valid, out_result, out_flags, sticky_flags
    );
`else
    modport slave (
        input  in_valid, in_a, in_b, div_result, out_ready,
        output in_ready, div_a, div_b, out_valid, out_result, out_flags
    );
    modport master (
        output in_valid, in_a, in_b, div_result, out_ready,
        input  in_ready, div_a, div_b, out_valid, out_result, out_flags
    );
`endif
endinterface

// File: rtl/fdiv_issue_stage.sv
// FP32 divide issue/retire stage around an external fixed-latency mantissa divide core.
// Optional sticky exception flags are built when FDIV_STICKY_FLAGS_EN is defined.
module fdiv_issue_stage #(
    parameter int XLEN        = 32,
    parameter int DIV_LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    fdiv_issue_stage_if.slave bus
);
    localparam int               CNT_W    = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_LATENCY - 1);

    localparam logic [XLEN-1:0] QNAN        = 32'h7FC0_0000;
    localparam logic [3:0]      FLG_INVALID = 4'b1000;
    localparam logic [3:0]      FLG_DBZ     = 4'b0100;
    localparam logic [3:0]      FLG_OVF     = 4'b0010;
    localparam logic [3:0]      FLG_UNF     = 4'b0001;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;
    typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} fp_class_e;

    function automatic fp_class_e classify(input logic [31:0] x);
        if (x[30:23] == 8'hFF) return (x[22:0] != 23'd0) ? CLS_NAN : CLS_INF;
        if (x[30:23] == 8'h00) return CLS_ZERO;
        return CLS_NORM;
    endfunction

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   div_a_q, div_b_q;
    logic              sign_q;
    logic [7:0]        ea_q, eb_q;
    logic [XLEN-1:0]   result_q;
    logic [3:0]        flags_q;

    fp_class_e         cls_a, cls_b;
    logic              sign_in;
    logic              is_special;
    logic [XLEN-1:0]   spec_result;
    logic [3:0]        spec_flags;
    logic signed [9:0] exp_sum;
    logic [XLEN-1:0]   norm_result;
    logic [3:0]        norm_flags;
    logic              accept;
    logic              capture;

    // The core's sign bit carries no information: sign always comes from the operands.
    logic unused_core_sign;
    assign unused_core_sign = bus.div_result[31];

    // NOTE: every variable written in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        cls_a       = classify(bus.in_a);
        cls_b       = classify(bus.in_b);
        sign_in     = bus.in_a[31] ^ bus.in_b[31];
        is_special  = !(cls_a == CLS_NORM && cls_b == CLS_NORM);
        spec_result = {sign_in, 31'd0};
        spec_flags  = 4'd0;
        if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
            (cls_a == CLS_ZERO && cls_b == CLS_ZERO) ||
            (cls_a == CLS_INF  && cls_b == CLS_INF)) begin
            spec_result = QNAN;
            spec_flags  = FLG_INVALID;
        end else if (cls_a == CLS_NORM && cls_b == CLS_ZERO) begin
            spec_result = {sign_in, 8'hFF, 23'd0};
            spec_flags  = FLG_DBZ;
        end else if (cls_a == CLS_INF) begin
            spec_result = {sign_in, 8'hFF, 23'd0};
        end
        // finite/Inf and 0/nonzero keep the signed-zero default
    end

    // Quotient of the normalised mantissas has exponent 126 or 127; re-bias it.
    always_comb begin
        exp_sum     = signed'({2'b00, ea_q}) - signed'({2'b00, eb_q})
                    + signed'({2'b00, bus.div_result[30:23]});
        norm_result = {sign_q, exp_sum[7:0], bus.div_result[22:0]};
        norm_flags  = 4'd0;
        if (exp_sum >= 10'sd255) begin
            norm_result = {sign_q, 8'hFF, 23'd0};
            norm_flags  = FLG_OVF;
        end else if (exp_sum <= 10'sd0) begin
            norm_result = {sign_q, 31'd0};
            norm_flags  = FLG_UNF;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = is_special ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state is assigned with <= only, so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            div_a_q  <= '0;
            div_b_q  <= '0;
            sign_q   <= 1'b0;
            ea_q     <= 8'd0;
            eb_q     <= 8'd0;
            result_q <= '0;
            flags_q  <= 4'd0;
        end else begin
            if (accept && is_special) begin
                result_q <= spec_result;
                flags_q  <= spec_flags;
            end
            if (accept && !is_special) begin
                div_a_q <= {1'b0, 8'd127, bus.in_a[22:0]};
                div_b_q <= {1'b0, 8'd127, bus.in_b[22:0]};
                sign_q  <= sign_in;
                ea_q    <= bus.in_a[30:23];
                eb_q    <= bus.in_b[30:23];
                cnt_q   <= CNT_LOAD;
            end else if (state_q == WAIT && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (capture) begin
                result_q <= norm_result;
                flags_q  <= norm_flags;
            end
        end
    end

    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = (state_q == DONE);
    assign bus.out_result = result_q;
    assign bus.out_flags  = flags_q;
    assign bus.div_a      = div_a_q;
    assign bus.div_b      = div_b_q;

`ifdef FDIV_STICKY_FLAGS_EN
    logic [3:0] sticky_q;

    // A clear in the same cycle as a retiring result wins.
    always_ff @(posedge clk) begin
        if (!rst_n)                              sticky_q <= 4'd0;
        else if (bus.flags_clr)                  sticky_q <= 4'd0;
        else if (bus.out_valid && bus.out_ready) sticky_q <= sticky_q | flags_q;
    end

    assign bus.sticky_flags = sticky_q;
`endif
endmodule

// File: tb/tb_fdiv_issue_stage.sv
// Self-checking bench for fdiv_issue_stage: directed vectors, multi-cycle corner
// sequences and random operands against an arithmetic reference model.
module tb_fdiv_issue_stage;
    localparam int L = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fdiv_issue_stage_if #(.XLEN(32)) bus ();

    fdiv_issue_stage #(.XLEN(32), .DIV_LATENCY(L)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    // Divide-core model: quotient of {1,ma}/{1,mb}, truncated, exponent 126/127.
    // The sign bit is deliberately set; the stage must ignore it.
    function automatic logic [31:0] core_q(input logic [31:0] a, input logic [31:0] b);
        longint num, den, m;
        num = longint'({1'b1, a[22:0]});
        den = longint'({1'b1, b[22:0]});
        if (num >= den) begin
            m = (num << 23) / den;
            return {1'b1, 8'd127, m[22:0]};
        end
        m = (num << 24) / den;
        return {1'b1, 8'd126, m[22:0]};
    endfunction

    // The core output is only correct once its inputs have been stable for L cycles.
    int          age = 0;
    logic [31:0] prev_a = '0, prev_b = '0;
    always @(negedge clk) begin
        if (bus.div_a !== prev_a || bus.div_b !== prev_b) age <= 1;
        else if (age < 1000)                              age <= age + 1;
        prev_a <= bus.div_a;
        prev_b <= bus.div_b;
    end
    assign bus.div_result = (age >= L) ? core_q(bus.div_a, bus.div_b)
                                       : (core_q(bus.div_a, bus.div_b) ^ 32'h0015_5555);

    // Reference: IEEE special-case rules plus exact mantissa division with truncation.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic [3:0] f,
                                    output bit special);
        bit     s, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
        int     ea, eb, e;
        longint num, den, qm;
        s      = a[31] ^ b[31];
        ea     = int'(a[30:23]);
        eb     = int'(b[30:23]);
        nan_a  = (ea == 255) && (a[22:0] != 0);
        nan_b  = (eb == 255) && (b[22:0] != 0);
        inf_a  = (ea == 255) && (a[22:0] == 0);
        inf_b  = (eb == 255) && (b[22:0] == 0);
        zero_a = (ea == 0);
        zero_b = (eb == 0);
        special = 1'b1;
        f = 4'b0000;
        if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
            r = 32'h7FC0_0000;
            f = 4'b1000;
        end else if (zero_b && !inf_a) begin
            r = {s, 8'hFF, 23'd0};
            f = 4'b0100;
        end else if (inf_a) begin
            r = {s, 8'hFF, 23'd0};
        end else if (inf_b || zero_a) begin
            r = {s, 31'd0};
        end else begin
            special = 1'b0;
            num = longint'({1'b1, a[22:0]});
            den = longint'({1'b1, b[22:0]});
            e   = ea - eb + 127;
            if (num < den) begin
                qm = (num << 24) / den;
                e  = e - 1;
            end else begin
                qm = (num << 23) / den;
            end
            if (e >= 255) begin
                r = {s, 8'hFF, 23'd0};
                f = 4'b0010;
            end else if (e <= 0) begin
                r = {s, 31'd0};
                f = 4'b0001;
            end else begin
                r = {s, e[7:0], qm[22:0]};
            end
        end
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        int          k;
        r = $urandom;
        k = $urandom_range(0, 11);
        case (k)
            0: r[30:0] = 31'd0;
            1: begin r[30:23] = 8'hFF; r[22:0] = 23'd0; end
            2: begin r[30:23] = 8'hFF; r[0] = 1'b1; end
            3: r[30:23] = 8'h00;
            4: r[30:23] = 8'($urandom_range(1, 3));
            5: r[30:23] = 8'($urandom_range(252, 254));
            default: r[30:23] = 8'($urandom_range(100, 154));
        endcase
        return r;
    endfunction

    // Issue one operation, measure cycles from acceptance to out_valid, optionally
    // hold out_ready low for `hold` cycles, then retire it.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int hold,
                         output logic [31:0] res, output logic [3:0] fl, output int lat);
        int waited;
        waited = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        while (!bus.in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("in_ready_at_issue", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        res = bus.out_result;
        fl  = bus.out_flags;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_out_result", bus.out_result, res);
            check("bp_out_flags", 32'(bus.out_flags), 32'(fl));
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flags;
        int          lat;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[$];
        logic [31:0] res, exp_r, exp_div_a, exp_div_b;
        logic [3:0]  fl, exp_f;
        int          lat, stale;
        bit          special;

        vecs.push_back('{32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, L + 1});
        vecs.push_back('{32'h3F80_0000, 32'h8000_0000, 32'hFF80_0000, 4'b0100, 1});
        vecs.push_back('{32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000, 1});
        vecs.push_back('{32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000, 1});
        vecs.push_back('{32'h7F7F_FFFF, 32'h0080_0000, 32'h7F80_0000, 4'b0010, L + 1});
        vecs.push_back('{32'h0080_0000, 32'h7F7F_FFFF, 32'h0000_0000, 4'b0001, L + 1});
        vecs.push_back('{32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 4'b1000, 1});
        vecs.push_back('{32'h7F80_0000, 32'h0000_0000, 32'h7F80_0000, 4'b0000, 1});
        vecs.push_back('{32'h3F80_0000, 32'hFF80_0000, 32'h8000_0000, 4'b0000, 1});
        vecs.push_back('{32'h0000_0000, 32'hC000_0000, 32'h8000_0000, 4'b0000, 1});
        vecs.push_back('{32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 4'b0000, 1});
        vecs.push_back('{32'hC040_0000, 32'h4000_0000, 32'hBFC0_0000, 4'b0000, L + 1});
        vecs.push_back('{32'h7F00_0000, 32'h3F00_0000, 32'h7F80_0000, 4'b0010, L + 1});
        vecs.push_back('{32'h7F00_0000, 32'h3F80_0000, 32'h7F00_0000, 4'b0000, L + 1});
        vecs.push_back('{32'h0080_0000, 32'h3FC0_0000, 32'h0000_0000, 4'b0001, L + 1});
        vecs.push_back('{32'h0100_0000, 32'h3FC0_0000, 32'h00AA_AAAA, 4'b0000, L + 1});

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
`ifdef FDIV_STICKY_FLAGS_EN
        bus.flags_clr = 1'b0;
`endif

        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_result", bus.out_result, 32'd0);
        check("rst_out_flags", 32'(bus.out_flags), 32'd0);
        check("rst_div_a", bus.div_a, 32'd0);
        check("rst_div_b", bus.div_b, 32'd0);
`ifdef FDIV_STICKY_FLAGS_EN
        check("rst_sticky", 32'(bus.sticky_flags), 32'd0);
`endif
        rst_n = 1'b1;

        exp_div_a = '0;
        exp_div_b = '0;
        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, 0, res, fl, lat);
            if (vecs[i].lat != 1) begin
                exp_div_a = {1'b0, 8'd127, vecs[i].a[22:0]};
                exp_div_b = {1'b0, 8'd127, vecs[i].b[22:0]};
            end
            check($sformatf("vec%0d_result", i), res, vecs[i].res);
            check($sformatf("vec%0d_flags", i), 32'(fl), 32'(vecs[i].flags));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_div_a", i), bus.div_a, exp_div_a);
            check($sformatf("vec%0d_div_b", i), bus.div_b, exp_div_b);
        end

        for (int i = 0; i < 150; i++) begin
            logic [31:0] ra, rb;
            ra = rand_fp();
            rb = rand_fp();
            ref_div(ra, rb, exp_r, exp_f, special);
            do_op(ra, rb, 0, res, fl, lat);
            check($sformatf("rnd%0d_result(%08h/%08h)", i, ra, rb), res, exp_r);
            check($sformatf("rnd%0d_flags", i), 32'(fl), 32'(exp_f));
            check($sformatf("rnd%0d_latency", i), 32'(lat), special ? 32'd1 : 32'(L + 1));
        end

        // Backpressure: result held for 5 cycles, stage frees one cycle after out_ready.
        do_op(32'h40C0_0000, 32'h4000_0000, 5, res, fl, lat);
        check("bp_result", res, 32'h4040_0000);
        check("bp_free_in_ready", 32'(bus.in_ready), 32'd1);
        check("bp_free_out_valid", 32'(bus.out_valid), 32'd0);

        // Reset in the middle of WAIT drops the operation.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = 32'h40C0_0000;
        bus.in_b     = 32'h4000_0000;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_out_flags", 32'(bus.out_flags), 32'd0);
        check("midrst_out_result", bus.out_result, 32'd0);
        check("midrst_div_a", bus.div_a, 32'd0);
        stale = 0;
        for (int i = 0; i < L + 4; i++) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        check("midrst_stale_valid", 32'(stale), 32'd0);

`ifdef FDIV_STICKY_FLAGS_EN
        check("sticky_after_reset", 32'(bus.sticky_flags), 32'd0);
        do_op(32'h3F80_0000, 32'h8000_0000, 0, res, fl, lat);
        do_op(32'h7F7F_FFFF, 32'h0080_0000, 0, res, fl, lat);
        check("sticky_accumulate", 32'(bus.sticky_flags), 32'b0110);
        @(negedge clk);
        bus.flags_clr = 1'b1;
        @(negedge clk);
        bus.flags_clr = 1'b0;
        check("sticky_clear", 32'(bus.sticky_flags), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
